// File: rtl/controller_datapath.sv
// One Game-of-Life generation on a 5x5 grid. The cells are processed one per cycle: a small FSM
// steps row/col, and the datapath counts neighbors from the frozen input grid.
module controller_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] line,
  output logic [24:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, UPDATE, DONE} state_t;

  state_t      state_reg;
  logic [2:0]  row_reg;
  logic [2:0]  col_reg;
  logic        done_reg;
  logic        busy_reg;
  logic [24:0] grid_reg;
  logic [24:0] next_grid_reg;
  logic [24:0] result_reg;

  logic        load_grid;
  logic        write_cell;
  logic        load_result;
  logic [48:0] padded;
  logic [5:0]  pidx;
  logic [3:0]  nbr_count;
  logic [4:0]  cell_idx;
  logic        cur_cell;
  logic        cell_next;

  // ---------------- controller ----------------
  assign load_grid   = (state_reg == IDLE) && start;
  assign write_cell  = (state_reg == CALC);
  assign load_result = (state_reg == UPDATE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      row_reg   <= 3'd0;
      col_reg   <= 3'd0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            row_reg   <= 3'd0;
            col_reg   <= 3'd0;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          if (col_reg == 3'd4) begin
            col_reg <= 3'd0;
            if (row_reg == 3'd4) begin
              row_reg   <= 3'd0;
              state_reg <= UPDATE;
            end else begin
              row_reg <= row_reg + 3'd1;
            end
          end else begin
            col_reg <= col_reg + 3'd1;
          end
        end
        UPDATE: begin
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  // The grid is surrounded by a ring of dead cells, so every neighbor lookup stays in range.
  genvar gi;
  generate
    for (gi = 0; gi < 49; gi++) begin : g_pad
      localparam int PR = gi / 7;
      localparam int PC = gi % 7;
      if (PR >= 1 && PR <= 5 && PC >= 1 && PC <= 5) begin : g_in
        assign padded[gi] = grid_reg[(PR - 1) * 5 + (PC - 1)];
      end else begin : g_edge
        assign padded[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    nbr_count = 4'd0;
    pidx      = 6'd0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        pidx = 6'(({3'b000, row_reg} + 6'(dr)) * 6'd7 + {3'b000, col_reg} + 6'(dc));
        if (!(dr == 1 && dc == 1))
          nbr_count = nbr_count + 4'(padded[pidx]);
      end
    end
  end

  assign cell_idx  = 5'({2'b00, row_reg} * 5'd5 + {2'b00, col_reg});
  assign cur_cell  = grid_reg[cell_idx];
  assign cell_next = (nbr_count == 4'd3) || ((nbr_count == 4'd2) && cur_cell);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grid_reg      <= 25'd0;
      next_grid_reg <= 25'd0;
      result_reg    <= 25'd0;
    end else begin
      if (load_grid)
        grid_reg <= line;
      if (write_cell)
        next_grid_reg[cell_idx] <= cell_next;
      if (load_result)
        result_reg <= next_grid_reg;
    end
  end

  assign result = result_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_controller_datapath.sv
// Bench for controller_datapath: fixed and random grids against a direct Life model,
// plus handshake, line-change, held-start and mid-run reset scenarios.
module tb_controller_datapath;

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] line;
  logic [24:0] result;
  logic        done;
  logic        busy;

  int total;
  int bad;
  logic [24:0] prev_result;

  controller_datapath dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .line   (line),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain Life rules with dead cells beyond the border.
  function automatic logic [24:0] life(input logic [24:0] g);
    logic [24:0] o;
    int n;
    int rr;
    int cc;
    o = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5)
              n += int'(g[rr * 5 + cc]);
          end
        end
        o[r * 5 + c] = (n == 3) || (n == 2 && g[r * 5 + c]);
      end
    end
    return o;
  endfunction

  // One computation; called at a negedge, returns at the negedge after E27.
  task automatic do_run(input logic [24:0] ln, input logic scramble, input string tag);
    logic [24:0] want;
    want  = life(ln);
    line  = ln;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 27; k++) begin
      if (k > 0) @(negedge clk);
      if (scramble && k == 5) line = 25'($urandom);
      total++;
      if (busy !== (k <= 26)) begin
        bad++;
        $display("FAIL %s busy k=%0d got=%b want=%b", tag, k, busy, (k <= 26));
      end
      total++;
      if (done !== (k == 26)) begin
        bad++;
        $display("FAIL %s done k=%0d got=%b want=%b", tag, k, done, (k == 26));
      end
      if (k == 25) begin
        total++;
        if (result !== prev_result) begin
          bad++;
          $display("FAIL %s result_hold got=%h want=%h", tag, result, prev_result);
        end
      end
      if (k == 26) begin
        total++;
        if (result !== want) begin
          bad++;
          $display("FAIL %s result line=%h got=%h want=%h", tag, ln, result, want);
        end else begin
          $display("run %s line=%h result=%h ok", tag, ln, result);
        end
      end
    end
    prev_result = want;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    line  = '0;
    repeat (3) @(negedge clk);
    total++;
    if (result !== 25'd0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b/%b want=0/0/0", result, done, busy);
    end else begin
      $display("reset state ok");
    end
    rst = 1'b1;
    prev_result = '0;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    do_run(25'h0003800, 1'b0, "blinker");
    total++;
    if (prev_result !== 25'h0021080) begin
      bad++;
      $display("FAIL blinker_const got=%h want=%h", prev_result, 25'h0021080);
    end
    do_run(25'h00018C0, 1'b0, "block");
    do_run(25'h0000000, 1'b0, "empty");
    do_run(25'h1FFFFFF, 1'b0, "full");
    do_run(25'h0003800, 1'b0, "blinker2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      do_run(25'($urandom), 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    do_run(25'($urandom), 1'b0, "b2b_a");
    do_run(25'($urandom), 1'b0, "b2b_b");
  endtask

  task automatic test_line_change();
    do_run(25'h0003800, 1'b1, "line_change");
    do_run(25'($urandom), 1'b1, "line_change_rand");
  endtask

  task automatic test_hold_start();
    logic [24:0] ln;
    int accepts[$];
    int done_at[$];
    logic exp_busy;
    ln = 25'($urandom);
    // Accept rule: an accepted start blocks the next one for 28 edges.
    for (int t = 0; t < 40; t += 28) accepts.push_back(t);
    line  = ln;
    start = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 39) start = 1'b0;
      if (done === 1'b1) done_at.push_back(cyc);
      exp_busy = 1'b0;
      foreach (accepts[i])
        if (cyc >= accepts[i] && cyc <= accepts[i] + 26) exp_busy = 1'b1;
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL hold_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
      end
    end
    total++;
    if (done_at.size() != accepts.size()) begin
      bad++;
      $display("FAIL hold_done_count got=%0d want=%0d", done_at.size(), accepts.size());
    end else begin
      foreach (accepts[i]) begin
        total++;
        if (done_at[i] != accepts[i] + 26) begin
          bad++;
          $display("FAIL hold_done_pos got=%0d want=%0d", done_at[i], accepts[i] + 26);
        end
      end
    end
    total++;
    if (result !== life(ln)) begin
      bad++;
      $display("FAIL hold_result got=%h want=%h", result, life(ln));
    end else begin
      $display("hold start line=%h result=%h dones=%0d", ln, result, done_at.size());
    end
    prev_result = life(ln);
  endtask

  task automatic test_reset_midrun();
    int dones;
    line  = 25'h0003800;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (result !== 25'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset got=%h/%b/%b want=0/0/0", result, busy, done);
    end else begin
      $display("mid-run reset cleared outputs");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL midrun_no_done got=%0d want=0", dones);
    end
    prev_result = '0;
    do_run(25'h0003800, 1'b0, "after_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_patterns();
    test_random();
    test_back_to_back();
    test_line_change();
    test_hold_start();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
